// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus bundle (instruction memory port, redirect, decode handshake, debug PC).
// master = fetch_unit side, slave = memory/decode/branch side.
interface fetch_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] instr_pc;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] fetch_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_pc,
        input  imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_pc,
        output imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing 1-cycle-latency imem reads into a PC-tagged prefetch FIFO feeding decode.
// Ports: clk, rst (async, active-high); bus (fetch_if.master): imem_req/imem_addr/imem_rdata,
// redirect_valid/redirect_pc, instr_valid/instr/instr_pc/instr_ready, fetch_pc (debug).
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input logic      clk,
    input logic      rst,
    fetch_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0]            fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic                             inflight_q, inflight_d;
    logic [CW-1:0]                    count_q, count_d;
    logic [AW-1:0]                    wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] pc_mem_q, pc_mem_d, ins_mem_q, ins_mem_d;
    logic [CW:0]                      occ;
    logic                             req, push, pop;

    always_comb begin
        // Occupancy includes the in-flight word; same-cycle pops are deliberately not credited.
        occ        = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        req        = !rst && !bus.redirect_valid && (occ < (CW+1)'(DEPTH));
        push       = inflight_q && !bus.redirect_valid;
        pop        = (count_q != '0) && bus.instr_ready && !bus.redirect_valid;
        fetch_pc_d = bus.redirect_valid ? (bus.redirect_pc & ~DATA_WIDTH'(3))
                                        : req ? fetch_pc_q + DATA_WIDTH'(4) : fetch_pc_q;
        resp_pc_d  = req ? fetch_pc_q : resp_pc_q;
        inflight_d = req;
        wr_d       = bus.redirect_valid ? '0 : wr_q + AW'(push);
        rd_d       = bus.redirect_valid ? '0 : rd_q + AW'(pop);
        count_d    = bus.redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        pc_mem_d   = pc_mem_q;
        ins_mem_d  = ins_mem_q;
        pc_mem_d[wr_q]  = push ? resp_pc_q : pc_mem_q[wr_q];
        ins_mem_d[wr_q] = push ? bus.imem_rdata : ins_mem_q[wr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            pc_mem_q   <= '0;
            ins_mem_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            pc_mem_q   <= pc_mem_d;
            ins_mem_q  <= ins_mem_d;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = count_q != '0;
    assign bus.instr       = ins_mem_q[rd_q];
    assign bus.instr_pc    = pc_mem_q[rd_q];
    assign bus.fetch_pc    = fetch_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, directed redirect/reset sequences and a queue scoreboard for fetch_unit.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if #(.DATA_WIDTH(32)) bus ();
    fetch_unit #(.DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endfunction

    always @(posedge clk) bus.imem_rdata <= bus.imem_addr >> 2;

    typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
    ent_t        sb[$];
    logic [31:0] m_pc;
    bit          m_infl;

    always @(negedge clk) begin
        bit er, ev;
        if (rst) begin
            sb.delete();
            m_pc   = 32'h0;
            m_infl = 1'b0;
        end else begin
            er = !bus.redirect_valid && sb.size() < 4;
            ev = (sb.size() - int'(m_infl)) > 0;
            chk("sb_req", {31'b0, bus.imem_req}, {31'b0, er});
            if (er) chk("sb_addr", bus.imem_addr, m_pc);
            chk("sb_fetch_pc", bus.fetch_pc, m_pc);
            chk("sb_valid", {31'b0, bus.instr_valid}, {31'b0, ev});
            if (ev) begin
                chk("sb_instr", bus.instr, sb[0].ins);
                chk("sb_instr_pc", bus.instr_pc, sb[0].pc);
            end
            if (bus.redirect_valid) begin
                sb.delete();
                m_infl = 1'b0;
                m_pc   = bus.redirect_pc & ~32'h3;
            end else begin
                if (ev && bus.instr_ready) begin
                    void'(sb.pop_front());
                    pops++;
                end
                if (er) begin
                    sb.push_back('{m_pc, m_pc >> 2});
                    m_pc   = m_pc + 32'd4;
                    m_infl = 1'b1;
                end else m_infl = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_fetch_pc", bus.fetch_pc, 32'h0);
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(string n, logic [31:0] exp_pc);
        int k = 0;
        while (!bus.instr_valid && k < 10) begin
            step();
            k++;
        end
        chk({n, "_timeout"}, {31'b0, bus.instr_valid}, 32'h1);
        chk({n, "_pc"}, bus.instr_pc, exp_pc);
    endtask

    typedef struct {bit rb; bit rdy; bit e_req; logic [31:0] e_addr; bit e_val; logic [31:0] e_pc;} vec_t;
    vec_t tab[$];

    initial begin
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tab = '{
            '{1, 1, 1, 32'h00, 0, 32'h00}, '{0, 1, 1, 32'h04, 0, 32'h00},
            '{0, 1, 1, 32'h08, 1, 32'h00}, '{0, 1, 1, 32'h0c, 1, 32'h04},
            '{0, 1, 1, 32'h10, 1, 32'h08}, '{0, 1, 1, 32'h14, 1, 32'h0c},
            '{1, 0, 1, 32'h00, 0, 32'h00}, '{0, 0, 1, 32'h04, 0, 32'h00},
            '{0, 0, 1, 32'h08, 1, 32'h00}, '{0, 0, 1, 32'h0c, 1, 32'h00},
            '{0, 0, 0, 32'h00, 1, 32'h00}, '{0, 0, 0, 32'h00, 1, 32'h00},
            '{0, 0, 0, 32'h00, 1, 32'h00}, '{0, 0, 0, 32'h00, 1, 32'h00},
            '{0, 0, 0, 32'h00, 1, 32'h00}, '{0, 0, 0, 32'h00, 1, 32'h00},
            '{0, 1, 0, 32'h00, 1, 32'h00}, '{0, 1, 1, 32'h10, 1, 32'h04},
            '{0, 1, 1, 32'h14, 1, 32'h08}, '{0, 1, 1, 32'h18, 1, 32'h0c},
            '{0, 1, 1, 32'h1c, 1, 32'h10}
        };
        step();
        foreach (tab[i]) begin
            if (tab[i].rb) do_reset();
            bus.instr_ready = tab[i].rdy;
            @(negedge clk);
            chk($sformatf("tab%0d_req", i), {31'b0, bus.imem_req}, {31'b0, tab[i].e_req});
            if (tab[i].e_req) chk($sformatf("tab%0d_addr", i), bus.imem_addr, tab[i].e_addr);
            chk($sformatf("tab%0d_valid", i), {31'b0, bus.instr_valid}, {31'b0, tab[i].e_val});
            if (tab[i].e_val) begin
                chk($sformatf("tab%0d_pc", i), bus.instr_pc, tab[i].e_pc);
                chk($sformatf("tab%0d_instr", i), bus.instr, tab[i].e_pc >> 2);
            end
            step();
        end

        do_reset();
        bus.instr_ready = 1'b1;
        repeat (5) step();
        bus.instr_ready = 1'b0;
        repeat (2) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        chk("redir_req", {31'b0, bus.imem_req}, 32'h0);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_valid_after", {31'b0, bus.instr_valid}, 32'h0);
        chk("redir_fetch_pc", bus.fetch_pc, 32'h100);
        chk("redir_req_after", {31'b0, bus.imem_req}, 32'h1);
        chk("redir_addr", bus.imem_addr, 32'h100);
        step();
        bus.instr_ready = 1'b1;
        wait_valid("redir_first", 32'h100);
        repeat (3) step();

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(negedge clk);
        chk("b2b_req0", {31'b0, bus.imem_req}, 32'h0);
        step();
        bus.redirect_pc = 32'h80;
        @(negedge clk);
        chk("b2b_req1", {31'b0, bus.imem_req}, 32'h0);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("b2b_addr", bus.imem_addr, 32'h80);
        step();
        wait_valid("b2b_first", 32'h80);

        pops = 0;
        repeat (1000) begin
            bus.instr_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("rand_progress", {31'b0, pops > 300}, 32'h1);

        do_reset();
        bus.instr_ready = 1'b0;
        repeat (3) step();
        chk("mid_valid_before", {31'b0, bus.instr_valid}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("mid_req", {31'b0, bus.imem_req}, 32'h0);
        chk("mid_instr", bus.instr, 32'h0);
        chk("mid_instr_pc", bus.instr_pc, 32'h0);
        chk("mid_fetch_pc", bus.fetch_pc, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_restart_req", {31'b0, bus.imem_req}, 32'h1);
        chk("mid_restart_addr", bus.imem_addr, 32'h0);
        bus.instr_ready = 1'b1;
        step();
        wait_valid("mid_first", 32'h0);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
